// File: rtl/univ_shift_reg.sv
// WIDTH-bit register with clr/pre/load and a counted shift/rotate burst engine.
// busy/done are decoded straight from the state register so async reset clears them at once.
module univ_shift_reg #(
    parameter int               WIDTH      = 8,
    parameter int               CNT_W      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             pre,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mode_lat;
    logic [1:0]       mode_sel;
    logic [WIDTH-1:0] q_shift;

    always_comb begin
        q_shift = q;
        case (mode_lat)
            2'b00:   q_shift = {q[WIDTH-2:0], sin};
            2'b01:   q_shift = {sin, q[WIDTH-1:1]};
            2'b10:   q_shift = {q[WIDTH-2:0], q[WIDTH-1]};
            default: q_shift = {q[0], q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= RESET_VAL;
            state    <= S_IDLE;
            cnt      <= '0;
            mode_lat <= 2'b00;
        end else if (!clr) begin
            q     <= RESET_VAL;
            state <= S_IDLE;
        end else if (!pre) begin
            q     <= PRESET_VAL;
            state <= S_IDLE;
        end else if (load) begin
            q     <= d;
            state <= S_IDLE;
        end else begin
            case (state)
                S_SHIFT: begin
                    q   <= q_shift;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= S_DONE;
                end
                S_IDLE, S_DONE: begin
                    // DONE accepts start just like IDLE so bursts can chain without a gap
                    if (start && amount != '0) begin
                        mode_lat <= mode;
                        cnt      <= amount;
                        state    <= S_SHIFT;
                    end else if (start) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (state == S_SHIFT);
    assign done     = (state == S_DONE);
    assign mode_sel = busy ? mode_lat : mode;
    assign sout     = mode_sel[0] ? q[0] : q[WIDTH-1];
    assign qbar     = ~q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed-vector bench: driver pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b1;
    logic       pre = 1'b1;
    logic       load = 1'b0;
    logic [7:0] d = 8'h00;
    logic [1:0] mode = 2'b00;
    logic       start = 1'b0;
    logic [3:0] amount = 4'd0;
    logic       sin = 1'b0;
    logic [7:0] q, qbar;
    logic       sout, busy, done;

    typedef struct packed {
        logic [7:0] q;
        logic       busy;
        logic       done;
        logic       sout;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;
    int   step_no = 0;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .pre(pre), .load(load), .d(d),
        .mode(mode), .start(start), .amount(amount), .sin(sin),
        .q(q), .qbar(qbar), .sout(sout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, checked mid-cycle on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                step_no++;
                total++;
                if (q !== e.q || qbar !== ~e.q || busy !== e.busy || done !== e.done || sout !== e.sout)
                    $display("FAIL step%0d: got q=%h qbar=%h busy=%b done=%b sout=%b, exp q=%h qbar=%h busy=%b done=%b sout=%b",
                             step_no, q, qbar, busy, done, sout, e.q, ~e.q, e.busy, e.done, e.sout);
                else
                    passed++;
            end
        end
    end

    // Inputs set before the call are sampled at the next posedge; expectation is the post-edge state.
    task automatic tick(input logic [7:0] eq, input logic eb, input logic ed, input logic es);
        @(posedge clk);
        #1;
        exp_q.push_back('{q: eq, busy: eb, done: ed, sout: es});
        @(negedge clk);
        #1;
    endtask

    initial begin
        // reset state
        #1 exp_q.push_back('{q: 8'h00, busy: 1'b0, done: 1'b0, sout: 1'b0});
        @(negedge clk); #1;
        rst = 1'b0;

        // load 0xA5, shift left by 3 with sin=0
        load = 1'b1; d = 8'hA5;
        tick(8'hA5, 0, 0, 1);
        load = 1'b0; start = 1'b1; mode = 2'b00; amount = 4'd3; sin = 1'b0;
        tick(8'hA5, 1, 0, 1);
        start = 1'b0;
        tick(8'h4A, 1, 0, 0);
        tick(8'h94, 1, 0, 1);
        tick(8'h28, 0, 1, 0);
        tick(8'h28, 0, 0, 0);

        // shift right by 2 with sin=1 from 0x00
        load = 1'b1; d = 8'h00;
        tick(8'h00, 0, 0, 0);
        load = 1'b0; start = 1'b1; mode = 2'b01; amount = 4'd2; sin = 1'b1;
        tick(8'h00, 1, 0, 0);
        start = 1'b0;
        tick(8'h80, 1, 0, 0);
        tick(8'hC0, 0, 1, 0);
        tick(8'hC0, 0, 0, 0);

        // rotate right by 1
        load = 1'b1; d = 8'h01; mode = 2'b00;
        tick(8'h01, 0, 0, 0);
        load = 1'b0; start = 1'b1; mode = 2'b11; amount = 4'd1;
        tick(8'h01, 1, 0, 1);
        start = 1'b0;
        tick(8'h80, 0, 1, 0);
        tick(8'h80, 0, 0, 0);

        // rotate left by WIDTH returns the original value
        load = 1'b1; d = 8'h3C; mode = 2'b00;
        tick(8'h3C, 0, 0, 0);
        load = 1'b0; start = 1'b1; mode = 2'b10; amount = 4'd8;
        tick(8'h3C, 1, 0, 0);
        start = 1'b0;
        tick(8'h78, 1, 0, 0);
        tick(8'hF0, 1, 0, 1);
        tick(8'hE1, 1, 0, 1);
        tick(8'hC3, 1, 0, 1);
        tick(8'h87, 1, 0, 1);
        tick(8'h0F, 1, 0, 0);
        tick(8'h1E, 1, 0, 0);
        tick(8'h3C, 0, 1, 0);
        tick(8'h3C, 0, 0, 0);

        // clr and pre together mid-burst: clr wins, no done
        load = 1'b1; d = 8'h3C; mode = 2'b00;
        tick(8'h3C, 0, 0, 0);
        load = 1'b0; start = 1'b1; amount = 4'd5; sin = 1'b1;
        tick(8'h3C, 1, 0, 0);
        start = 1'b0;
        tick(8'h79, 1, 0, 0);
        clr = 1'b0; pre = 1'b0;
        tick(8'h00, 0, 0, 0);
        clr = 1'b1; pre = 1'b1;
        tick(8'h00, 0, 0, 0);

        // pre alone mid-burst
        start = 1'b1; amount = 4'd4; sin = 1'b0;
        tick(8'h00, 1, 0, 0);
        start = 1'b0; pre = 1'b0;
        tick(8'hFF, 0, 0, 1);
        pre = 1'b1;
        tick(8'hFF, 0, 0, 1);

        // left shift by 10 (> WIDTH) fills entirely with sin
        load = 1'b1; d = 8'h00;
        tick(8'h00, 0, 0, 0);
        load = 1'b0; start = 1'b1; mode = 2'b00; amount = 4'd10; sin = 1'b1;
        tick(8'h00, 1, 0, 0);
        start = 1'b0;
        tick(8'h01, 1, 0, 0);
        tick(8'h03, 1, 0, 0);
        tick(8'h07, 1, 0, 0);
        tick(8'h0F, 1, 0, 0);
        tick(8'h1F, 1, 0, 0);
        tick(8'h3F, 1, 0, 0);
        tick(8'h7F, 1, 0, 0);
        tick(8'hFF, 1, 0, 1);
        tick(8'hFF, 1, 0, 1);
        tick(8'hFF, 0, 1, 1);
        tick(8'hFF, 0, 0, 1);

        // async reset between edges during a burst
        load = 1'b1; d = 8'hA5; sin = 1'b0;
        tick(8'hA5, 0, 0, 1);
        load = 1'b0; start = 1'b1; amount = 4'd4;
        tick(8'hA5, 1, 0, 1);
        start = 1'b0;
        tick(8'h4A, 1, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        exp_q.push_back('{q: 8'h00, busy: 1'b0, done: 1'b0, sout: 1'b0});
        @(negedge clk); #1;
        rst = 1'b0;
        // zero-amount burst: done next cycle, never busy
        start = 1'b1; amount = 4'd0;
        tick(8'h00, 0, 1, 0);
        start = 1'b0;
        tick(8'h00, 0, 0, 0);

        // start held high: ignored while busy, chains from DONE without a gap
        load = 1'b1; d = 8'h81;
        tick(8'h81, 0, 0, 1);
        load = 1'b0; start = 1'b1; mode = 2'b10; amount = 4'd2;
        tick(8'h81, 1, 0, 1);
        mode = 2'b01; amount = 4'd5;
        tick(8'h03, 1, 0, 0);
        tick(8'h06, 0, 1, 0);
        mode = 2'b11; amount = 4'd1;
        tick(8'h06, 1, 0, 0);
        start = 1'b0;
        tick(8'h03, 0, 1, 1);
        tick(8'h03, 0, 0, 1);

        // every pushed expectation must have been consumed
        @(negedge clk); #1;
        total++;
        if (exp_q.size() != 0)
            $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit D flop: a WIDTH-bit register with the same clr/pre/d load semantics.
- Adds a multi-cycle shift/rotate burst engine: counted shifts in four modes, with busy/done status.
- Serves as a building block for serialisers, LFSR seeding and barrel-style alignment in later datapaths.

Parameters:
- WIDTH, 8, register width in bits (must be >= 2).
- CNT_W, 4, width of amount and the internal counter; the shift count per burst can be at most 2^CNT_W - 1.
- RESET_VAL, {WIDTH{1'b0}}, value of q on rst.
- PRESET_VAL, {WIDTH{1'b1}}, value loaded by pre.

Ports:
- clk  input  1  clock; all sequential logic is on the posedge.
- rst  input  1  reset, asynchronous and active-high.
- clr  input  1  synchronous clear, active-low.
- pre  input  1  synchronous preset, active-low.
- load  input  1  synchronous parallel load of d, active-high.
- d  input  WIDTH  parallel load data.
- mode  input  2  burst mode: 00 shift left, 01 shift right, 10 rotate left, 11 rotate right.
- start  input  1  burst request, sampled on a clock edge.
- amount  input  CNT_W  number of single-bit shifts in the burst.
- sin  input  1  serial fill bit for shift modes, sampled on every shift edge.
- q  output  WIDTH  register contents.
- qbar  output  WIDTH  ~q, combinational.
- sout  output  1  next bit to leave the register.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse when a burst completes.

Behaviour:
- rst=1, asynchronous: q=RESET_VAL, state=IDLE, busy=0, done=0, counter=0, latched mode=00. Takes effect immediately, including mid-burst.
- Edge priority: clr=0 > pre=0 > load=1 > burst activity.
  - clr: q=RESET_VAL.
  - pre: q=PRESET_VAL.
  - load: q=d.
  - Any of the three aborts an active burst: state goes to IDLE, busy=0, and done is not pulsed.
- States:
  - IDLE: start=1 with amount>0 latches mode and amount, then goes to SHIFT with busy=1. start=1 with amount==0 goes to DONE, and q is unchanged.
  - SHIFT: on every edge, perform one shift by the latched mode and decrement the counter. The edge that performs the last shift moves to DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then IDLE. start is honoured in DONE exactly as in IDLE, so bursts can run back-to-back.
- Latency: with start sampled at edge k and amount=n>0:
  - shifts occur at edges k+1 .. k+n;
  - busy=1 after edge k through edge k+n-1;
  - done=1 in the cycle after edge k+n.
- start while in SHIFT is ignored, and mode/amount changes mid-burst have no effect.
- Shift semantics:
  - Left shift: q={q[WIDTH-2:0],sin}.
  - Right shift: q={sin,q[WIDTH-1:1]}.
  - Rotate modes ignore sin.
  - amount >= WIDTH is legal and is not clamped. A left/right shift by >= WIDTH leaves q fully filled with sin history; a rotate by WIDTH returns the original value.
- sout = q[WIDTH-1] for modes 00/10, and q[0] for modes 01/11. The mode used is the latched mode while busy and the mode input otherwise.
- Outside a burst, with no clr/pre/load, q holds its value.

Test Plan:
- WIDTH=8: load d=0xA5, then start mode=00 amount=3 sin=0 → q=0x4A, 0x94, 0x28 on successive edges; busy high for 3 cycles; done pulses once; sout=1, 0, 1, 0.
- q=0x00, start mode=01 amount=2 sin=1 → q=0x80, then 0xC0; done pulses one cycle after the 0xC0 edge.
- Rotate: q=0x01, mode=11 amount=1 → 0x80. q=0x3C, mode=10 amount=8 → 0x3C after 8 shifts, with busy high for 8 cycles.
- Mid-burst: clr=0 and pre=0 on the same edge → q=0x00, busy=0, no done pulse. pre=0 alone → q=0xFF.
- Assert rst between clock edges during a burst → q=0x00 and busy=0 immediately, before the next edge. After release, start amount=0 → done pulses at the next edge, q is unchanged, busy is never high.
- start re-asserted while busy is ignored (the shift count is still the original amount). start held high in DONE → a second burst begins with no idle gap.
